// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: turns the hazard unit's stall request, decode-stage
// branch resolution and HLT detection into pipeline-register controls for a
// 5-stage pipeline. It also drains the pipeline on HLT, holds the halted
// state, and flags stall runs longer than any legal load-use stall.
//
// Optional feature: define PIPE_HAZARD_PERF_CNT_EN to add the stall/flush
// performance counters (stall_cnt, flush_cnt).
//
// Ports:
//   clk            pipeline clock
//   rst            synchronous, active-high reset
//   stallFD        load-use stall request from the hazard unit
//   branch_taken_D branch in D resolved taken this cycle
//   halt_D         HLT decoded in D this cycle
//   pc_en          PC register write enable
//   if_id_en       IF/ID register enable
//   if_id_flush    IF/ID loads a NOP
//   id_ex_bubble   ID/EX loads a NOP with zeroed control
//   halted         processor halted
//   stall_err      sticky: a stall run exceeded MAX_STALL
//   stall_cnt      total stall cycles        (optional feature only)
//   flush_cnt      total branch-flush cycles (optional feature only)
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MAX_STALL    = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallFD,
  input  logic             branch_taken_D,
  input  logic             halt_D,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic             stall_err
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [1:0]  StallSat = 2'(MAX_STALL + 1);
  localparam logic [1:0]  StallMax = 2'(MAX_STALL);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StStall     = 2'd1,
    StHaltDrain = 2'd2,
    StHalted    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        consec_q, consec_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              err_q, err_d;
  logic              do_stall, do_flush;

  always_comb begin
    state_d      = state_q;
    consec_d     = consec_q;
    drain_d      = drain_q;
    err_d        = err_q;
    do_stall     = 1'b0;
    do_flush     = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    halted       = 1'b0;

    unique case (state_q)
      StRun, StStall: begin
        if (stallFD) begin
          // Branch/halt operands are not ready yet, so both are ignored.
          do_stall     = 1'b1;
          if_id_flush  = 1'b0;
          state_d      = StStall;
          consec_d     = (consec_q == StallSat) ? consec_q : consec_q + 2'd1;
        end else if (halt_D) begin
          // HLT advances to EX; the fetched instruction behind it is dropped.
          if_id_en     = 1'b1;
          id_ex_bubble = 1'b0;
          state_d      = StHaltDrain;
          drain_d      = DrainW'(1);
          consec_d     = 2'd0;
        end else if (branch_taken_D) begin
          do_flush     = 1'b1;
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          id_ex_bubble = 1'b0;
          state_d      = StRun;
          consec_d     = 2'd0;
        end else begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b0;
          id_ex_bubble = 1'b0;
          state_d      = StRun;
          consec_d     = 2'd0;
        end
        if (consec_d > StallMax) begin
          err_d = 1'b1;
        end
      end
      StHaltDrain: begin
        drain_d = drain_q + DrainW'(1);
        if (drain_q == DrainLast) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Reset overrides the outputs in the same cycle it is asserted.
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      halted       = 1'b0;
    end
  end

  assign stall_err = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      consec_q <= 2'd0;
      drain_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // do_stall/do_flush are only raised in RUN/STALL, so the counters
  // naturally freeze while draining or halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (do_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (do_flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = rst ? '0 : stall_cnt_q;
  assign flush_cnt = rst ? '0 : flush_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = do_stall ^ do_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well clear of the
// rising edge. Counter checks are compiled in with PIPE_HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst, stallFD, branch_taken_D, halt_D;
  logic pc_en, if_id_en, if_id_flush, id_ex_bubble, halted, stall_err;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallFD        (stallFD),
    .branch_taken_D (branch_taken_D),
    .halt_D         (halt_D),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .halted         (halted),
    .stall_err      (stall_err)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then let outputs settle.
  task automatic drive(input logic r, input logic s, input logic b, input logic h);
    @(negedge clk);
    rst            = r;
    stallFD        = s;
    branch_taken_D = b;
    halt_D         = h;
    #1;
  endtask

  // Outputs packed as {pc_en, if_id_en, if_id_flush, id_ex_bubble, halted}.
  function automatic logic [4:0] ctl();
    return {pc_en, if_id_en, if_id_flush, id_ex_bubble, halted};
  endfunction

  localparam logic [4:0] CtlRst    = 5'b00110;
  localparam logic [4:0] CtlNorm   = 5'b11000;
  localparam logic [4:0] CtlStall  = 5'b00010;
  localparam logic [4:0] CtlHaltD  = 5'b01100;
  localparam logic [4:0] CtlBranch = 5'b11100;
  localparam logic [4:0] CtlDrain  = 5'b00110;
  localparam logic [4:0] CtlHalted = 5'b00111;

  initial begin
    rst = 1'b1; stallFD = 1'b0; branch_taken_D = 1'b0; halt_D = 1'b0;

    // Reset, with noisy inputs to show they are overridden.
    drive(1, 1, 0, 0);
    chk("rst_ctl", ctl(), CtlRst);
    chk("rst_err", stall_err, 1'b0);
    drive(1, 0, 1, 1);
    chk("rst_ctl2", ctl(), CtlRst);

    // Idle after release.
    drive(0, 0, 0, 0);
    chk("idle1", ctl(), CtlNorm);
    drive(0, 0, 0, 0);
    chk("idle2", ctl(), CtlNorm);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("cnt_start_stall", stall_cnt, 16'd0);
    chk("cnt_start_flush", flush_cnt, 16'd0);
`endif

    // Legal 2-cycle load-use stall.
    drive(0, 1, 0, 0);
    chk("stall2_c1", ctl(), CtlStall);
    drive(0, 1, 0, 0);
    chk("stall2_c2", ctl(), CtlStall);
    drive(0, 0, 0, 0);
    chk("stall2_after", ctl(), CtlNorm);
    chk("stall2_err", stall_err, 1'b0);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("stall2_cnt", stall_cnt, 16'd2);
`endif

    // 3-cycle stall run: error flag rises after the 3rd cycle and sticks.
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("stall3_c3_ctl", ctl(), CtlStall);
    chk("stall3_c3_err", stall_err, 1'b0);
    drive(0, 0, 0, 0);
    chk("stall3_err_set", stall_err, 1'b1);
    chk("stall3_after", ctl(), CtlNorm);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("stall3_err_sticky", stall_err, 1'b1);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("stall3_cnt", stall_cnt, 16'd5);
`endif

    // Branch under a stall is ignored, then resolved the next cycle.
    drive(0, 1, 1, 0);
    chk("br_stalled", ctl(), CtlStall);
    drive(0, 0, 1, 0);
    chk("br_taken", ctl(), CtlBranch);
    drive(0, 0, 0, 0);
    chk("br_after", ctl(), CtlNorm);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("br_flush_cnt", flush_cnt, 16'd1);
    chk("br_stall_cnt", stall_cnt, 16'd6);
`endif

    // Halt and branch together: halt wins.
    drive(0, 0, 1, 1);
    chk("halt_d", ctl(), CtlHaltD);
    for (int i = 0; i < 3; i++) begin
      drive(0, i[0], ~i[0], 1);
      chk("drain", ctl(), CtlDrain);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, i[0], i[1], 0);
      chk("halted", ctl(), CtlHalted);
    end
    chk("halted_err", stall_err, 1'b1);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("halted_stall_frz", stall_cnt, 16'd6);
    chk("halted_flush_frz", flush_cnt, 16'd1);
`endif

    // Reset out of HALTED clears the sticky error.
    drive(1, 0, 0, 0);
    chk("rst2_ctl", ctl(), CtlRst);
    drive(0, 0, 0, 0);
    chk("rst2_norm", ctl(), CtlNorm);
    chk("rst2_err", stall_err, 1'b0);

    // Reset during the 2nd drain cycle discards the halt.
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
    chk("mid_halt_d", ctl(), CtlHaltD);
    drive(0, 0, 0, 0);
    chk("mid_drain1", ctl(), CtlDrain);
    drive(1, 0, 0, 0);
    chk("mid_rst", ctl(), CtlRst);
    drive(0, 0, 0, 0);
    chk("mid_norm", ctl(), CtlNorm);
    drive(0, 0, 0, 0);
    chk("mid_norm2", ctl(), CtlNorm);
    chk("mid_err", stall_err, 1'b0);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("mid_stall_cnt", stall_cnt, 16'd0);
    chk("mid_flush_cnt", flush_cnt, 16'd0);
`endif

    // A fresh halt drains fully again after the aborted one.
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("fresh_drain3", ctl(), CtlDrain);
    drive(0, 0, 0, 0);
    chk("fresh_halted", ctl(), CtlHalted);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
